// File: rtl/instr_fetch.sv
// instr_fetch
// -----------
// Instruction fetch stage feeding the decoder (ID). Owns the program counter,
// issues word fetches over a req/ack handshake, holds each fetched word and
// its address stable until ID accepts it, and redirects on a taken branch.
// A fetch already handed to memory is always completed. If a branch arrives
// while that fetch is still waiting, the returned word is dropped.
//
// Ports:
//   clk           system clock, rising-edge active
//   rst           synchronous active-high reset
//   imem_req      fetch request to instruction memory (decoded from state)
//   imem_addr     fetch byte address (current pc)
//   imem_ack      memory returns imem_rdata this cycle
//   imem_rdata    fetched instruction word
//   instruction   instruction presented to ID
//   instr_pc      address of the presented instruction
//   instr_valid   instruction/instr_pc are valid
//   id_ready      ID accepts the presented instruction
//   branch_valid  redirect request
//   branch_target redirect address (low two bits ignored)

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        id_ready,
  input  logic        branch_valid,
  input  logic [31:0] branch_target
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pending_pc;
  logic [31:0] target_aligned;

  // Branch targets are always word aligned.
  assign target_aligned = branch_target & ~32'h3;

  // FLUSH keeps presenting the abandoned address so the outstanding
  // handshake completes exactly as memory saw it.
  assign imem_req  = (state == FETCH) || (state == FLUSH);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pending_pc  <= 32'h0;
      instruction <= 32'h0;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
    end else if (branch_valid) begin
      // A branch wins over ack and id_ready; whatever is presented or in
      // flight belongs to the wrong path.
      instr_valid <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          pc    <= target_aligned;
          state <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            pc    <= target_aligned;
            state <= FETCH;
          end else begin
            pending_pc <= target_aligned;
            state      <= FLUSH;
          end
        end
        default: begin
          pending_pc <= target_aligned;
          if (imem_ack) begin
            pc    <= target_aligned;
            state <= FETCH;
          end
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            instruction <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 32'(PC_STEP);
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (id_ready) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        default: begin
          if (imem_ack) begin
            pc    <= pending_pc;
            state <= FETCH;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus a randomized run checked
// against a transaction-level reference model of the fetch stage.

module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        branch_valid;
  logic [31:0] branch_target;

  logic        a_req, b_req;
  logic [31:0] a_addr, b_addr;
  logic [31:0] a_instr, b_instr;
  logic [31:0] a_ipc, b_ipc;
  logic        a_valid, b_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state for dut_a (RESET_PC = 0)
  logic [31:0] m_pc;
  logic        m_dead;
  logic        m_held;
  logic        m_drain;
  logic [31:0] m_redirect;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut_a (
    .clk(clk), .rst(rst),
    .imem_req(a_req), .imem_addr(a_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(a_instr), .instr_pc(a_ipc), .instr_valid(a_valid),
    .id_ready(id_ready),
    .branch_valid(branch_valid), .branch_target(branch_target)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_b (
    .clk(clk), .rst(rst),
    .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(b_instr), .instr_pc(b_ipc), .instr_valid(b_valid),
    .id_ready(id_ready),
    .branch_valid(branch_valid), .branch_target(branch_target)
  );

  // Model: a fetch stage either sits out its post-reset dead cycle, holds a
  // word for ID, drains a wrong-path fetch, or requests m_pc.
  task automatic model_update();
    logic [31:0] tgt;
    tgt = {branch_target[31:2], 2'b00};
    if (rst) begin
      m_pc = 32'h0; m_dead = 1'b1; m_held = 1'b0; m_drain = 1'b0;
      m_instr = 32'h0; m_ipc = 32'h0; m_redirect = 32'h0;
    end else if (m_dead) begin
      m_dead = 1'b0;
      if (branch_valid) m_pc = tgt;
    end else if (branch_valid) begin
      if (m_held) begin
        m_held = 1'b0;
        m_pc = tgt;
      end else if (imem_ack) begin
        m_drain = 1'b0;
        m_pc = tgt;
      end else begin
        m_drain = 1'b1;
        m_redirect = tgt;
      end
    end else if (m_held) begin
      if (id_ready) m_held = 1'b0;
    end else if (m_drain) begin
      if (imem_ack) begin
        m_drain = 1'b0;
        m_pc = m_redirect;
      end
    end else if (imem_ack) begin
      m_held = 1'b1;
      m_instr = imem_rdata;
      m_ipc = m_pc;
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled at negedge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    id_ready = 1'b0; branch_valid = 1'b0; branch_target = 32'h0;
    tick(); tick();
    checks++; if (a_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b want 0", a_req); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", a_valid); end
    checks++; if (a_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got %h want 0", a_instr); end
    checks++; if (a_ipc !== 32'h0) begin errors++; $display("[TB] FAIL reset_ipc got %h want 0", a_ipc); end
    checks++; if (b_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_b_valid got %b want 0", b_valid); end
  endtask

  task automatic test_zero_wait();
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_FFFF; id_ready = 1'b0;
    checks++; if (a_req !== 1'b0) begin errors++; $display("[TB] FAIL dead_cycle_req got %b want 0", a_req); end
    tick();
    checks++; if (a_req !== 1'b1 || a_addr !== 32'h0) begin errors++; $display("[TB] FAIL first_req got %b/%h want 1/00000000", a_req, a_addr); end
    tick();
    checks++; if (a_valid !== 1'b1 || a_instr !== 32'h0000_FFFF || a_ipc !== 32'h0) begin
      errors++; $display("[TB] FAIL first_word got %b/%h/%h want 1/0000ffff/00000000", a_valid, a_instr, a_ipc); end
    checks++; if (a_req !== 1'b0) begin errors++; $display("[TB] FAIL hold_req got %b want 0", a_req); end
    id_ready = 1'b1; imem_rdata = 32'h0200_EEEE;
    tick();
    checks++; if (a_valid !== 1'b0 || a_req !== 1'b1 || a_addr !== 32'h4) begin
      errors++; $display("[TB] FAIL second_req got v%b r%b %h want v0 r1 00000004", a_valid, a_req, a_addr); end
    id_ready = 1'b0;
    tick();
    checks++; if (a_valid !== 1'b1 || a_instr !== 32'h0200_EEEE || a_ipc !== 32'h4) begin
      errors++; $display("[TB] FAIL second_word got %b/%h/%h want 1/0200eeee/00000004", a_valid, a_instr, a_ipc); end
  endtask

  task automatic test_backpressure();
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0; imem_rdata = 32'h0640_0000;
    tick();
    for (int i = 0; i < 3; i++) begin
      imem_rdata = $urandom;
      checks++; if (a_valid !== 1'b1 || a_instr !== 32'h0640_0000 || a_ipc !== 32'h8 || a_req !== 1'b0) begin
        errors++; $display("[TB] FAIL backpressure_%0d got v%b %h %h r%b want v1 06400000 00000008 r0", i, a_valid, a_instr, a_ipc, a_req); end
      tick();
    end
    id_ready = 1'b1;
    tick();
    checks++; if (a_valid !== 1'b0 || a_req !== 1'b1 || a_addr !== 32'hC) begin
      errors++; $display("[TB] FAIL release got v%b r%b %h want v0 r1 0000000c", a_valid, a_req, a_addr); end
    id_ready = 1'b0;
  endtask

  task automatic test_branch_hold();
    imem_ack = 1'b1; imem_rdata = 32'h7777_0000;
    tick();
    branch_valid = 1'b1; branch_target = 32'h0000_0103;
    tick();
    branch_valid = 1'b0;
    checks++; if (a_valid !== 1'b0 || a_req !== 1'b1 || a_addr !== 32'h100) begin
      errors++; $display("[TB] FAIL branch_hold got v%b r%b %h want v0 r1 00000100", a_valid, a_req, a_addr); end
  endtask

  task automatic test_slow_branch();
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    tick();
    branch_valid = 1'b1; branch_target = 32'h0000_0200;
    tick();
    branch_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (a_req !== 1'b1 || a_addr !== 32'h100 || a_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL flush_%0d got r%b %h v%b want r1 00000100 v0", i, a_req, a_addr, a_valid); end
      tick();
    end
    imem_ack = 1'b1;
    tick();
    checks++; if (a_req !== 1'b1 || a_addr !== 32'h200 || a_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL after_flush got r%b %h v%b want r1 00000200 v0", a_req, a_addr, a_valid); end
    imem_rdata = 32'h1111_2222;
    tick();
    checks++; if (a_valid !== 1'b1 || a_instr !== 32'h1111_2222 || a_ipc !== 32'h200) begin
      errors++; $display("[TB] FAIL branch_word got %b/%h/%h want 1/11112222/00000200", a_valid, a_instr, a_ipc); end
  endtask

  task automatic test_wrap();
    rst = 1'b1; imem_ack = 1'b1; id_ready = 1'b0; branch_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (b_req !== 1'b1 || b_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("[TB] FAIL wrap_first got r%b %h want r1 fffffffc", b_req, b_addr); end
    tick();
    checks++; if (b_valid !== 1'b1 || b_ipc !== 32'hFFFF_FFFC) begin
      errors++; $display("[TB] FAIL wrap_word got v%b %h want v1 fffffffc", b_valid, b_ipc); end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    checks++; if (b_req !== 1'b1 || b_addr !== 32'h0) begin
      errors++; $display("[TB] FAIL wrap_second got r%b %h want r1 00000000", b_req, b_addr); end
    rst = 1'b1;
    tick();
    checks++; if (b_req !== 1'b0 || b_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL midfetch_reset got r%b v%b want r0 v0", b_req, b_valid); end
    rst = 1'b0;
    tick();
    checks++; if (b_req !== 1'b1 || b_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("[TB] FAIL restart got r%b %h want r1 fffffffc", b_req, b_addr); end
  endtask

  task automatic test_random();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      imem_ack      = $urandom_range(0, 1) == 1;
      imem_rdata    = $urandom;
      id_ready      = $urandom_range(0, 2) != 0;
      branch_valid  = ($urandom_range(0, 6) == 0);
      branch_target = $urandom;
      checks++; if (a_req !== (!m_dead && !m_held)) begin
        errors++; $display("[TB] FAIL rand_req cycle %0d got %b want %b", i, a_req, !m_dead && !m_held); end
      if (!m_dead && !m_held) begin
        checks++; if (a_addr !== m_pc) begin
          errors++; $display("[TB] FAIL rand_addr cycle %0d got %h want %h", i, a_addr, m_pc); end
      end
      checks++; if (a_valid !== m_held) begin
        errors++; $display("[TB] FAIL rand_valid cycle %0d got %b want %b", i, a_valid, m_held); end
      if (m_held) begin
        checks++; if (a_instr !== m_instr || a_ipc !== m_ipc) begin
          errors++; $display("[TB] FAIL rand_word cycle %0d got %h@%h want %h@%h", i, a_instr, a_ipc, m_instr, m_ipc); end
      end
      tick();
    end
    rst = 1'b0; branch_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
    branch_valid = 1'b0; branch_target = 32'h0;
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_branch_hold();
    test_slow_branch();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
